// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit that owns the architectural HI/LO registers.
// Define MDU_MADD_EN to enable the multiply-accumulate ops (MADD, MADDU, MSUB, MSUBU).
module mdu #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  op,
   input  logic [31:0] num1,
   input  logic [31:0] num2,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        op_invalid
);

   localparam logic [3:0] OP_NOP   = 4'd0;
   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
   localparam logic [3:0] OP_MADD  = 4'd7;
   localparam logic [3:0] OP_MADDU = 4'd8;
   localparam logic [3:0] OP_MSUB  = 4'd9;
   localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

   localparam logic [4:0] MULT_N = 5'(MULT_CYCLES);
   localparam logic [4:0] DIV_N  = 5'(DIV_CYCLES);

   typedef enum logic {IDLE, RUN} state_t;

   state_t      state, state_next;
   logic [4:0]  count, count_next;
   logic [63:0] result, result_next;
   logic [31:0] hi_next, lo_next;
   logic        op_invalid_next;

   logic [63:0] prod_s, prod_u;
   logic [31:0] mag1, mag2, safe_mag2, safe_num2;
   logic [31:0] uq, ur, sq, sr, udq, udr;
   logic        div_zero;

   // Products are formed on the live operands; the mod-2^64 product of the
   // sign-extended operands is exactly the signed 64-bit product.
   assign prod_u = {32'd0, num1} * {32'd0, num2};
   assign prod_s = {{32{num1[31]}}, num1} * {{32{num2[31]}}, num2};

   // Signed divide works on magnitudes so truncation toward zero and the
   // dividend-signed remainder fall out directly; 0x80000000 / -1 yields
   // quotient 0x80000000 and remainder 0 without a special case.
   assign div_zero  = (num2 == 32'd0);
   assign safe_num2 = div_zero ? 32'd1 : num2;
   assign mag1      = num1[31] ? -num1 : num1;
   assign mag2      = num2[31] ? -num2 : num2;
   assign safe_mag2 = div_zero ? 32'd1 : mag2;
   assign uq        = mag1 / safe_mag2;
   assign ur        = mag1 % safe_mag2;
   assign sq        = (num1[31] ^ num2[31]) ? -uq : uq;
   assign sr        = num1[31] ? -ur : ur;
   assign udq       = num1 / safe_num2;
   assign udr       = num1 % safe_num2;

`ifdef MDU_MADD_EN
   logic [63:0] acc;
   assign acc = {hi, lo};
`endif

   assign busy = (state == RUN);

   // State, counter, latched result and HI/LO registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         count      <= 5'd0;
         result     <= 64'd0;
         hi         <= 32'd0;
         lo         <= 32'd0;
         op_invalid <= 1'b0;
      end else begin
         state      <= state_next;
         count      <= count_next;
         result     <= result_next;
         hi         <= hi_next;
         lo         <= lo_next;
         op_invalid <= op_invalid_next;
      end
   end

   // Next-state logic: IDLE decodes and latches the full result at the start
   // edge; RUN only counts down and commits {hi,lo} as a single update.
   always_comb begin
      state_next      = state;
      count_next      = count;
      result_next     = result;
      hi_next         = hi;
      lo_next         = lo;
      op_invalid_next = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               case (op)
                  OP_NOP: begin
                  end
                  OP_MULT: begin
                     result_next = prod_s;
                     count_next  = MULT_N;
                     state_next  = RUN;
                  end
                  OP_MULTU: begin
                     result_next = prod_u;
                     count_next  = MULT_N;
                     state_next  = RUN;
                  end
                  OP_DIV: begin
                     result_next = div_zero ? {num1, 32'hffff_ffff} : {sr, sq};
                     count_next  = DIV_N;
                     state_next  = RUN;
                  end
                  OP_DIVU: begin
                     result_next = div_zero ? {num1, 32'hffff_ffff} : {udr, udq};
                     count_next  = DIV_N;
                     state_next  = RUN;
                  end
                  OP_MTHI: hi_next = num1;
                  OP_MTLO: lo_next = num1;
`ifdef MDU_MADD_EN
                  OP_MADD: begin
                     result_next = acc + prod_s;
                     count_next  = MULT_N;
                     state_next  = RUN;
                  end
                  OP_MADDU: begin
                     result_next = acc + prod_u;
                     count_next  = MULT_N;
                     state_next  = RUN;
                  end
                  OP_MSUB: begin
                     result_next = acc - prod_s;
                     count_next  = MULT_N;
                     state_next  = RUN;
                  end
                  OP_MSUBU: begin
                     result_next = acc - prod_u;
                     count_next  = MULT_N;
                     state_next  = RUN;
                  end
`endif
                  default: op_invalid_next = 1'b1;
               endcase
            end
         end
         RUN: begin
            if (count == 5'd1) begin
               hi_next    = result[63:32];
               lo_next    = result[31:0];
               count_next = 5'd0;
               state_next = IDLE;
            end else begin
               count_next = count - 5'd1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: expected {hi,lo} values go into a scoreboard
// queue at issue time and are popped when busy falls.
module tb_mdu;

   localparam int MULT_N = 5;
   localparam int DIV_N  = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [3:0]  op;
   logic [31:0] num1, num2;
   logic        busy;
   logic [31:0] hi, lo;
   logic        op_invalid;

   int          total = 0;
   int          bad   = 0;
   logic [63:0] sb_q[$];
   logic [63:0] model_hilo;

   localparam logic [3:0]  DIV_OP [8] = '{4'd4, 4'd3, 4'd3, 4'd3, 4'd4, 4'd3, 4'd4, 4'd3};
   localparam logic [31:0] DIV_A  [8] = '{32'h0000000b, 32'hfffffff5, 32'h12345678, 32'h80000000,
                                          32'h00000005, 32'h00000007, 32'hffffffff, 32'h80000000};
   localparam logic [31:0] DIV_B  [8] = '{32'h00000003, 32'h00000003, 32'h00000000, 32'hffffffff,
                                          32'h00000000, 32'hfffffffe, 32'h00000010, 32'h00000007};
   localparam logic [63:0] DIV_EXP[8] = '{64'h00000002_00000003, 64'hfffffffe_fffffffd,
                                          64'h12345678_ffffffff, 64'h00000000_80000000,
                                          64'h00000005_ffffffff, 64'h00000001_fffffffd,
                                          64'h0000000f_0fffffff, 64'hfffffffe_edb6db6e};

   always #5 clk = ~clk;

   mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .num1(num1), .num2(num2),
      .busy(busy), .hi(hi), .lo(lo), .op_invalid(op_invalid)
   );

   function automatic logic [63:0] ref_mul(input logic sgn, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa, sb;
      if (sgn) begin
         sa = 64'($signed(a));
         sb = 64'($signed(b));
         return sa * sb;
      end
      return {32'd0, a} * {32'd0, b};
   endfunction

   // Called at a negedge; returns at the following negedge with start dropped
   // and the operands scrambled so late sampling would be noticed.
   task automatic applyStimulus(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
      start = 1'b1; op = o; num1 = a; num2 = b;
      @(negedge clk);
      start = 1'b0; op = 4'd0; num1 = $urandom; num2 = $urandom;
   endtask

   task automatic wait_idle(output int cycles);
      cycles = 0;
      while (busy === 1'b1 && cycles < 100) begin
         @(negedge clk);
         cycles++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; op = 4'd0; num1 = 32'd0; num2 = 32'd0;
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      total++; if ({hi, lo} !== 64'd0) begin bad++; $display("[TB] FAIL reset_hilo: got %h expected 0", {hi, lo}); end
      total++; if (op_invalid !== 1'b0) begin bad++; $display("[TB] FAIL reset_inv: got %b expected 0", op_invalid); end
      @(negedge clk);
      reset = 1'b0;
      model_hilo = 64'd0;
   endtask

   task automatic test_mult();
      logic [3:0]  o;
      logic [31:0] a, b;
      logic [63:0] exp;
      int          cyc;
      for (int i = 0; i < 7; i++) begin
         if (i == 0) begin o = 4'd1; a = 32'hfffffffe; b = 32'h3; exp = 64'hffffffff_fffffffa; end
         else if (i == 1) begin o = 4'd1; a = 32'h80000000; b = 32'h80000000; exp = 64'h40000000_00000000; end
         else if (i == 2) begin o = 4'd2; a = 32'hffffffff; b = 32'hffffffff; exp = 64'hfffffffe_00000001; end
         else begin
            o = (i % 2 == 1) ? 4'd1 : 4'd2; a = $urandom; b = $urandom;
            exp = ref_mul(o == 4'd1, a, b);
         end
         sb_q.push_back(exp);
         applyStimulus(o, a, b);
         total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL mult_busy[%0d]: got %b expected 1", i, busy); end
         total++; if ({hi, lo} !== model_hilo) begin bad++; $display("[TB] FAIL mult_hold[%0d]: got %h expected %h", i, {hi, lo}, model_hilo); end
         wait_idle(cyc);
         total++; if (cyc != MULT_N) begin bad++; $display("[TB] FAIL mult_cycles[%0d]: got %0d expected %0d", i, cyc, MULT_N); end
         exp = sb_q.pop_front();
         total++; if ({hi, lo} !== exp) begin bad++; $display("[TB] FAIL mult_result[%0d]: got %h expected %h", i, {hi, lo}, exp); end
         model_hilo = exp;
      end
   endtask

   task automatic test_div();
      logic [63:0] exp;
      int          cyc;
      for (int i = 0; i < 8; i++) begin
         sb_q.push_back(DIV_EXP[i]);
         applyStimulus(DIV_OP[i], DIV_A[i], DIV_B[i]);
         total++; if ({hi, lo} !== model_hilo) begin bad++; $display("[TB] FAIL div_hold[%0d]: got %h expected %h", i, {hi, lo}, model_hilo); end
         wait_idle(cyc);
         total++; if (cyc != DIV_N) begin bad++; $display("[TB] FAIL div_cycles[%0d]: got %0d expected %0d", i, cyc, DIV_N); end
         exp = sb_q.pop_front();
         total++; if ({hi, lo} !== exp) begin bad++; $display("[TB] FAIL div_result[%0d]: got %h expected %h", i, {hi, lo}, exp); end
         model_hilo = exp;
      end
   endtask

   task automatic test_move();
      start = 1'b1; op = 4'd5; num1 = 32'hdeadbeef; num2 = 32'd0;
      @(negedge clk);
      total++; if (hi !== 32'hdeadbeef) begin bad++; $display("[TB] FAIL mthi: got %h expected deadbeef", hi); end
      total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL mthi_busy: got %b expected 0", busy); end
      op = 4'd6; num1 = 32'h01234567;
      @(negedge clk);
      start = 1'b0; op = 4'd0;
      total++; if ({hi, lo} !== 64'hdeadbeef_01234567) begin bad++; $display("[TB] FAIL mtlo: got %h expected deadbeef01234567", {hi, lo}); end
      total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL mtlo_busy: got %b expected 0", busy); end
      model_hilo = 64'hdeadbeef_01234567;
   endtask

   task automatic test_busy_ignore();
      logic [63:0] exp;
      int          cyc;
      bit          moved;
      sb_q.push_back(64'h00000000_0000000c);
      applyStimulus(4'd1, 32'd3, 32'd4);
      start = 1'b1; op = 4'd4; num1 = 32'd100; num2 = 32'd7;
      @(negedge clk);
      op = 4'd13;
      @(negedge clk);
      start = 1'b0; op = 4'd0;
      total++; if (op_invalid !== 1'b0) begin bad++; $display("[TB] FAIL ignore_inv: got %b expected 0", op_invalid); end
      total++; if ({hi, lo} !== model_hilo) begin bad++; $display("[TB] FAIL ignore_hold: got %h expected %h", {hi, lo}, model_hilo); end
      wait_idle(cyc);
      total++; if (cyc != MULT_N - 2) begin bad++; $display("[TB] FAIL ignore_cycles: got %0d expected %0d", cyc, MULT_N - 2); end
      exp = sb_q.pop_front();
      total++; if ({hi, lo} !== exp) begin bad++; $display("[TB] FAIL ignore_result: got %h expected %h", {hi, lo}, exp); end
      model_hilo = exp;
      moved = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (busy !== 1'b0 || {hi, lo} !== exp) moved = 1'b1;
      end
      total++; if (moved !== 1'b0) begin bad++; $display("[TB] FAIL ignore_late: got %b expected 0", moved); end
   endtask

   task automatic test_back_to_back();
      logic [63:0] exp;
      int          cyc;
      sb_q.push_back(ref_mul(1'b0, 32'h00012345, 32'h00abcdef));
      sb_q.push_back(64'h00000004_00000024);
      applyStimulus(4'd2, 32'h00012345, 32'h00abcdef);
      wait_idle(cyc);
      total++; if (cyc != MULT_N) begin bad++; $display("[TB] FAIL b2b_cycles0: got %0d expected %0d", cyc, MULT_N); end
      exp = sb_q.pop_front();
      total++; if ({hi, lo} !== exp) begin bad++; $display("[TB] FAIL b2b_result0: got %h expected %h", {hi, lo}, exp); end
      applyStimulus(4'd3, 32'h00000100, 32'h00000007);
      total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL b2b_accept: got %b expected 1", busy); end
      wait_idle(cyc);
      total++; if (cyc != DIV_N) begin bad++; $display("[TB] FAIL b2b_cycles1: got %0d expected %0d", cyc, DIV_N); end
      exp = sb_q.pop_front();
      total++; if ({hi, lo} !== exp) begin bad++; $display("[TB] FAIL b2b_result1: got %h expected %h", {hi, lo}, exp); end
      model_hilo = exp;
   endtask

   task automatic test_reset_mid_run();
      bit moved;
      applyStimulus(4'd2, 32'hffffffff, 32'hffffffff);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
      total++; if ({hi, lo} !== 64'd0) begin bad++; $display("[TB] FAIL abort_hilo: got %h expected 0", {hi, lo}); end
      @(negedge clk);
      reset = 1'b0;
      model_hilo = 64'd0;
      moved = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (busy !== 1'b0 || {hi, lo} !== 64'd0) moved = 1'b1;
      end
      total++; if (moved !== 1'b0) begin bad++; $display("[TB] FAIL abort_late: got %b expected 0", moved); end
   endtask

   task automatic test_invalid();
      applyStimulus(4'd13, 32'h11111111, 32'h22222222);
      total++; if (op_invalid !== 1'b1) begin bad++; $display("[TB] FAIL inv_pulse: got %b expected 1", op_invalid); end
      total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL inv_busy: got %b expected 0", busy); end
      @(negedge clk);
      total++; if (op_invalid !== 1'b0) begin bad++; $display("[TB] FAIL inv_width: got %b expected 0", op_invalid); end
      total++; if ({hi, lo} !== model_hilo) begin bad++; $display("[TB] FAIL inv_hilo: got %h expected %h", {hi, lo}, model_hilo); end
      applyStimulus(4'd0, 32'h33333333, 32'h44444444);
      total++; if (op_invalid !== 1'b0 || busy !== 1'b0) begin bad++; $display("[TB] FAIL nop_flags: got inv=%b busy=%b expected 0 0", op_invalid, busy); end
      total++; if ({hi, lo} !== model_hilo) begin bad++; $display("[TB] FAIL nop_hilo: got %h expected %h", {hi, lo}, model_hilo); end
`ifndef MDU_MADD_EN
      applyStimulus(4'd7, 32'd2, 32'd3);
      total++; if (op_invalid !== 1'b1 || busy !== 1'b0) begin bad++; $display("[TB] FAIL madd_off: got inv=%b busy=%b expected 1 0", op_invalid, busy); end
      @(negedge clk);
      total++; if ({hi, lo} !== model_hilo) begin bad++; $display("[TB] FAIL madd_off_hilo: got %h expected %h", {hi, lo}, model_hilo); end
`endif
   endtask

`ifdef MDU_MADD_EN
   task automatic test_madd();
      logic [3:0]  o;
      logic [31:0] a, b;
      logic [63:0] exp;
      int          cyc;
      applyStimulus(4'd6, 32'd5, 32'd0);
      applyStimulus(4'd5, 32'd0, 32'd0);
      total++; if ({hi, lo} !== 64'd5) begin bad++; $display("[TB] FAIL madd_init: got %h expected 5", {hi, lo}); end
      model_hilo = 64'd5;
      for (int i = 0; i < 4; i++) begin
         case (i)
            0: begin o = 4'd7;  a = 32'd2;        b = 32'd3; exp = 64'h00000000_0000000b; end
            1: begin o = 4'd10; a = 32'd4;        b = 32'd4; exp = 64'hffffffff_fffffffb; end
            2: begin o = 4'd9;  a = 32'hffffffff; b = 32'd2; exp = 64'hffffffff_fffffffd; end
            default: begin o = 4'd8; a = 32'hffffffff; b = 32'd2; exp = 64'h00000001_fffffffb; end
         endcase
         sb_q.push_back(exp);
         applyStimulus(o, a, b);
         total++; if ({hi, lo} !== model_hilo) begin bad++; $display("[TB] FAIL madd_hold[%0d]: got %h expected %h", i, {hi, lo}, model_hilo); end
         wait_idle(cyc);
         total++; if (cyc != MULT_N) begin bad++; $display("[TB] FAIL madd_cycles[%0d]: got %0d expected %0d", i, cyc, MULT_N); end
         exp = sb_q.pop_front();
         total++; if ({hi, lo} !== exp) begin bad++; $display("[TB] FAIL madd_result[%0d]: got %h expected %h", i, {hi, lo}, exp); end
         model_hilo = exp;
      end
   endtask
`endif

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_move();
      test_busy_ignore();
      test_back_to_back();
      test_reset_mid_run();
      test_invalid();
`ifdef MDU_MADD_EN
      test_madd();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
